lv_abist_mc: RTL and testbench
==============================

Name: lv_abist_mc

Overview:
Multi-channel analog BIST sequencer for the LV die. It generalises the single-channel OV self-test to CH_NUM detectors and tests each unmasked channel in turn. For each channel it forces the BIST stimulus and checks that the detector flag asserts within a window. It then releases the stimulus and checks that the flag de-asserts, which catches stuck-at-high detectors. After the last channel it reports per-channel fail bits and hands over to logic BIST.

Parameters:
CH_NUM, 4, number of analog detector channels (1..16).
CLK_M, 48, i_clk cycles per microsecond.
WIN_US, 70, force window per channel, in us; WIN_CYC = WIN_US*CLK_M.
REL_US, 10, release window per channel, in us; REL_CYC = REL_US*CLK_M.
FILT_CYC, 3, number of consecutive equal samples needed to accept a flag level (>=1).

Ports:
i_clk  in  1  system clock.
i_rst_n  in  1  reset.
i_bist_en  in  1  BIST session enable; a low level aborts and clears the session.
i_ch_mask  in  CH_NUM  1 = skip this channel (no force, never fails).
i_det_flag  in  CH_NUM  detector outputs, already synchronised to i_clk.
o_bist_force  out  CH_NUM  one-hot stimulus to the analog channel under test.
o_bist_busy  out  1  high while the sequencer is not in IDLE or DONE.
o_bist_done  out  1  sequence complete.
o_ch_fail  out  CH_NUM  per-channel sticky fail bits.
o_abist_fail  out  1  OR of o_ch_fail, registered.
o_lbist_en  out  1  logic BIST enable.

Behaviour:
- Clock and reset: reset i_rst_n is asynchronous, active-low; clock i_clk.
- Reset state: all outputs 0, FSM in IDLE, ch_idx = 0, all counters 0.
- All outputs come directly from flops, so there are no combinational glitches on the analog controls.
- Counters:
  - Window counter: width $clog2(max(WIN_CYC,REL_CYC)+1).
  - Filter counter: width $clog2(FILT_CYC+1); saturating.
  - ch_idx: width $clog2(CH_NUM+1).
- FSM states: IDLE, SEL, FORCE, RELEASE, DONE.
- Abort: i_bist_en = 0 in any state moves the FSM to IDLE on the next edge. That same edge clears all outputs, counters and ch_idx. This has priority over every transition below.
- IDLE: when i_bist_en = 1, go to SEL with ch_idx = 0.
- SEL (1 cycle per visited index):
  - If ch_idx == CH_NUM, go to DONE.
  - Else if i_ch_mask[ch_idx] = 1, increment ch_idx and stay in SEL.
  - Else go to FORCE and clear both counters.
  - i_ch_mask is sampled only in SEL.
- FORCE:
  - o_bist_force = one-hot(ch_idx), registered: high on every cycle the FSM is in FORCE.
  - The window counter increments each cycle.
  - The filter counter increments while i_det_flag[ch_idx] = 1 and clears to 0 on any sample of 0.
  - Pass: filter counter reaches FILT_CYC, then go to RELEASE.
  - Fail: window counter reaches WIN_CYC-1 with no pass. Set o_ch_fail[ch_idx] and go to RELEASE.
  - If pass and timeout occur in the same cycle, pass wins.
  - Both counters clear on exit.
- RELEASE:
  - o_bist_force = 0.
  - The filter counter counts consecutive samples of i_det_flag[ch_idx] = 0.
  - Pass: filter counter reaches FILT_CYC. Increment ch_idx and go to SEL.
  - Fail: window counter reaches REL_CYC-1 with no pass. Set o_ch_fail[ch_idx], increment ch_idx and go to SEL.
  - A channel that fails in FORCE is still checked in RELEASE; its fail bit only ORs.
- DONE:
  - o_bist_done = 1, o_lbist_en = 1, o_bist_busy = 0.
  - Hold until i_bist_en = 0.
  - A new session requires i_bist_en to go low then high again.
- o_ch_fail is sticky within a session and cleared only by abort or reset.
- o_abist_fail is registered from OR(o_ch_fail), so it lags o_ch_fail by 1 cycle.
- o_bist_busy = 1 in SEL, FORCE and RELEASE.
- If all channels are masked: 1 cycle in IDLE, CH_NUM+1 cycles in SEL, then DONE with o_ch_fail = 0.
- Flags of channels not under test are ignored.

Test Plan:
All cases use CH_NUM=4, CLK_M=4 (WIN_CYC=280, REL_CYC=40), FILT_CYC=3, mask=0, unless stated.
1. All pass: each i_det_flag follows its o_bist_force with a 5-cycle delay -> channels forced in order 0,1,2,3, each for 8 cycles; then o_bist_done=1, o_lbist_en=1, o_ch_fail=4'b0000, o_abist_fail=0.
2. Channel 2 flag held at 0 -> o_bist_force[2] high for exactly 280 cycles; o_ch_fail=4'b0100; o_abist_fail=1 one cycle later; channel 3 is still tested.
3. Channel 1 flag stuck at 1 -> FORCE passes after 3 cycles; RELEASE times out after 40 cycles; o_ch_fail=4'b0010.
4. i_ch_mask=4'b1010 -> only bits 0 and 2 of o_bist_force ever assert; mask=4'b1111 -> o_bist_done asserts 6 cycles after i_bist_en rises, with no force.
5. Glitch filter: on channel 0, flag pulses high for 2 cycles, low for 1 cycle, then stays high -> pass is declared 3 cycles after the final rise, never on the 2-cycle pulse.
6. Abort and reset: drop i_bist_en in cycle 100 of channel 1 FORCE -> next edge all outputs are 0 and the FSM is in IDLE; re-enabling restarts from channel 0. Asserting i_rst_n low mid-RELEASE clears all outputs asynchronously.

Source files
------------

// File: rtl/lv_abist_mc.sv
`default_nettype none
// ============================================================================
// Module   : lv_abist_mc
// Brief    : Multi-channel analog BIST sequencer. Each unmasked detector
//            channel is forced in turn and must assert its flag within the
//            force window, then de-assert it within the release window.
//            Per-channel sticky fail bits are reported, and logic BIST is
//            enabled when the sweep completes.
// Revision : 1.0 - initial release
// ============================================================================
module lv_abist_mc #(
  parameter int CH_NUM   = 4,
  parameter int CLK_M    = 48,
  parameter int WIN_US   = 70,
  parameter int REL_US   = 10,
  parameter int FILT_CYC = 3
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_bist_en,
  input  logic [CH_NUM-1:0] i_ch_mask,
  input  logic [CH_NUM-1:0] i_det_flag,
  output logic [CH_NUM-1:0] o_bist_force,
  output logic              o_bist_busy,
  output logic              o_bist_done,
  output logic [CH_NUM-1:0] o_ch_fail,
  output logic              o_abist_fail,
  output logic              o_lbist_en
);

  localparam int c_WIN_CYC = WIN_US * CLK_M;
  localparam int c_REL_CYC = REL_US * CLK_M;
  localparam int c_MAX_CYC = (c_WIN_CYC > c_REL_CYC) ? c_WIN_CYC : c_REL_CYC;
  localparam int c_WCW     = $clog2(c_MAX_CYC + 1);
  localparam int c_FCW     = $clog2(FILT_CYC + 1);
  localparam int c_IW      = $clog2(CH_NUM + 1);

  localparam logic [c_WCW-1:0]  c_WIN_LAST  = c_WCW'(c_WIN_CYC - 1);
  localparam logic [c_WCW-1:0]  c_REL_LAST  = c_WCW'(c_REL_CYC - 1);
  localparam logic [c_FCW-1:0]  c_FILT_LAST = c_FCW'(FILT_CYC - 1);
  localparam logic [c_FCW-1:0]  c_FILT_MAX  = c_FCW'(FILT_CYC);
  localparam logic [c_IW-1:0]   c_CH_END    = c_IW'(CH_NUM);
  localparam logic [CH_NUM-1:0] c_ONE       = CH_NUM'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SEL     = 3'd1,
    S_FORCE   = 3'd2,
    S_RELEASE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t            r_state;
  logic [c_IW-1:0]   r_ch_idx;
  logic [c_WCW-1:0]  r_win;
  logic [c_FCW-1:0]  r_filt;
  logic [CH_NUM-1:0] r_force;
  logic [CH_NUM-1:0] r_ch_fail;
  logic              r_busy;
  logic              r_done;
  logic              r_abist_fail;
  logic              r_lbist_en;

  logic [CH_NUM-1:0] w_onehot;
  logic              w_mask_bit;
  logic              w_flag;
  logic [c_FCW-1:0]  w_filt_inc;
  logic [c_WCW-1:0]  w_win_inc;

  // Select the channel under test; an index of CH_NUM shifts out to all-zero,
  // so the end-of-sweep index never selects a mask or flag bit.
  always_comb begin
    w_onehot   = c_ONE << r_ch_idx;
    w_mask_bit = |(i_ch_mask & w_onehot);
    w_flag     = |(i_det_flag & w_onehot);
    w_filt_inc = (r_filt == c_FILT_MAX) ? r_filt : r_filt + c_FCW'(1);
    w_win_inc  = r_win + c_WCW'(1);
  end

  // Sequencer FSM; all outputs are registered and change on state transitions.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_ch_idx     <= '0;
      r_win        <= '0;
      r_filt       <= '0;
      r_force      <= '0;
      r_ch_fail    <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_abist_fail <= 1'b0;
      r_lbist_en   <= 1'b0;
    end else if (!i_bist_en) begin
      // Dropping the enable aborts the session from any state.
      r_state      <= S_IDLE;
      r_ch_idx     <= '0;
      r_win        <= '0;
      r_filt       <= '0;
      r_force      <= '0;
      r_ch_fail    <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_abist_fail <= 1'b0;
      r_lbist_en   <= 1'b0;
    end else begin
      r_abist_fail <= |r_ch_fail;
      case (r_state)
        S_IDLE: begin
          r_state  <= S_SEL;
          r_ch_idx <= '0;
          r_busy   <= 1'b1;
        end
        S_SEL: begin
          if (r_ch_idx == c_CH_END) begin
            r_state    <= S_DONE;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_lbist_en <= 1'b1;
          end else if (w_mask_bit) begin
            r_ch_idx <= r_ch_idx + c_IW'(1);
          end else begin
            r_state <= S_FORCE;
            r_win   <= '0;
            r_filt  <= '0;
            r_force <= w_onehot;
          end
        end
        S_FORCE: begin
          // A filtered pass takes precedence over a coincident timeout.
          if (w_flag && (r_filt == c_FILT_LAST)) begin
            r_state <= S_RELEASE;
            r_win   <= '0;
            r_filt  <= '0;
            r_force <= '0;
          end else if (r_win == c_WIN_LAST) begin
            r_state   <= S_RELEASE;
            r_win     <= '0;
            r_filt    <= '0;
            r_force   <= '0;
            r_ch_fail <= r_ch_fail | w_onehot;
          end else begin
            r_win  <= w_win_inc;
            r_filt <= w_flag ? w_filt_inc : '0;
          end
        end
        S_RELEASE: begin
          // A flag that never drops marks a stuck-high detector.
          if (!w_flag && (r_filt == c_FILT_LAST)) begin
            r_state  <= S_SEL;
            r_ch_idx <= r_ch_idx + c_IW'(1);
            r_win    <= '0;
            r_filt   <= '0;
          end else if (r_win == c_REL_LAST) begin
            r_state   <= S_SEL;
            r_ch_idx  <= r_ch_idx + c_IW'(1);
            r_win     <= '0;
            r_filt    <= '0;
            r_ch_fail <= r_ch_fail | w_onehot;
          end else begin
            r_win  <= w_win_inc;
            r_filt <= w_flag ? '0 : w_filt_inc;
          end
        end
        S_DONE: begin
          r_state <= S_DONE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_bist_force = r_force;
  assign o_bist_busy  = r_busy;
  assign o_bist_done  = r_done;
  assign o_ch_fail    = r_ch_fail;
  assign o_abist_fail = r_abist_fail;
  assign o_lbist_en   = r_lbist_en;

endmodule
`default_nettype wire

// File: tb/tb_lv_abist_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_lv_abist_mc
// Brief    : Self-checking bench for lv_abist_mc (CH_NUM=4, CLK_M=4,
//            FILT_CYC=3, giving WIN_CYC=280 and REL_CYC=40).
// Revision : 1.0 - initial release
// ============================================================================
module tb_lv_abist_mc;

  localparam int CH = 4;
  localparam int BUDGET = 3000;

  logic          i_clk;
  logic          i_rst_n;
  logic          i_bist_en;
  logic [CH-1:0] i_ch_mask;
  logic [CH-1:0] i_det_flag;
  logic [CH-1:0] o_bist_force;
  logic          o_bist_busy;
  logic          o_bist_done;
  logic [CH-1:0] o_ch_fail;
  logic          o_abist_fail;
  logic          o_lbist_en;

  lv_abist_mc #(
    .CH_NUM  (CH),
    .CLK_M   (4),
    .WIN_US  (70),
    .REL_US  (10),
    .FILT_CYC(3)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_bist_en   (i_bist_en),
    .i_ch_mask   (i_ch_mask),
    .i_det_flag  (i_det_flag),
    .o_bist_force(o_bist_force),
    .o_bist_busy (o_bist_busy),
    .o_bist_done (o_bist_done),
    .o_ch_fail   (o_ch_fail),
    .o_abist_fail(o_abist_fail),
    .o_lbist_en  (o_lbist_en)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Detector model: 0 = follows force with 5-cycle delay, 1 = stuck 0,
  // 2 = stuck 1, 3 = driven from script_flag.
  logic [1:0]    mode [CH];
  logic          script_flag;
  logic [CH-1:0] hist [5];

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < 5; k++) hist[k] <= '0;
    end else begin
      hist[0] <= o_bist_force;
      for (int k = 1; k < 5; k++) hist[k] <= hist[k-1];
    end
  end

  always_comb begin
    i_det_flag = '0;
    for (int k = 0; k < CH; k++) begin
      case (mode[k])
        2'd0:    i_det_flag[k] = hist[4][k];
        2'd1:    i_det_flag[k] = 1'b0;
        2'd2:    i_det_flag[k] = 1'b1;
        default: i_det_flag[k] = script_flag;
      endcase
    end
  end

  int n_cmp;
  int n_err;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [3:0]  mask;
    logic [7:0]  modes;     // {ch3,ch2,ch1,ch0}
    logic [3:0]  exp_fail;
    logic [39:0] exp_len;   // 10 bits per channel, {ch3,ch2,ch1,ch0}
  } vec_t;

  function automatic vec_t mk(input string n, input logic [3:0] m, input logic [7:0] md,
                              input logic [3:0] f, input logic [39:0] l);
    vec_t v;
    v.name = n; v.mask = m; v.modes = md; v.exp_fail = f; v.exp_len = l;
    return v;
  endfunction

  task automatic set_modes(input logic [7:0] md);
    for (int k = 0; k < CH; k++) mode[k] = md[k*2 +: 2];
  endtask

  task automatic idle_cycles(input int n);
    i_bist_en = 1'b0;
    repeat (n) @(negedge i_clk);
  endtask

  // Run one full session and compare end-of-sweep results against the record.
  task automatic run_vec(input vec_t v);
    int  flen [CH];
    int  bad_force;
    int  lag_err;
    int  cyc;
    logic prev_or;
    i_ch_mask = v.mask;
    set_modes(v.modes);
    for (int k = 0; k < CH; k++) flen[k] = 0;
    bad_force = 0;
    lag_err   = 0;
    cyc       = 0;
    prev_or   = |o_ch_fail;
    i_bist_en = 1'b1;
    while (!o_bist_done && cyc < BUDGET) begin
      @(negedge i_clk);
      cyc++;
      for (int k = 0; k < CH; k++) if (o_bist_force[k]) flen[k]++;
      if ($countones(o_bist_force) > 1 || (o_bist_force & v.mask) != '0) bad_force++;
      if (o_abist_fail !== prev_or) lag_err++;
      prev_or = |o_ch_fail;
    end
    check({v.name, ".done"},  32'(o_bist_done), 32'd1);
    check({v.name, ".lbist"}, 32'(o_lbist_en), 32'd1);
    check({v.name, ".busy"},  32'(o_bist_busy), 32'd0);
    check({v.name, ".fail"},  32'(o_ch_fail), 32'(v.exp_fail));
    check({v.name, ".abist"}, 32'(o_abist_fail), 32'(|v.exp_fail));
    for (int k = 0; k < CH; k++)
      check($sformatf("%s.force_len%0d", v.name, k), 32'(flen[k]), 32'(v.exp_len[k*10 +: 10]));
    check({v.name, ".force_onehot_unmasked"}, 32'(bad_force), 32'd0);
    check({v.name, ".abist_lag"}, 32'(lag_err), 32'd0);
    i_bist_en = 1'b0;
    @(negedge i_clk);
    check({v.name, ".done_cleared"}, {30'd0, o_bist_done, o_lbist_en}, 32'd0);
    idle_cycles(8);
  endtask

  vec_t vecs [7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int busy_cnt;
    int force_seen;
    logic seen;
    n_cmp = 0;
    n_err = 0;
    script_flag = 1'b0;
    for (int k = 0; k < CH; k++) mode[k] = 2'd0;
    i_rst_n   = 1'b0;
    i_bist_en = 1'b0;
    i_ch_mask = '0;

    vecs[0] = mk("all_pass",      4'b0000, 8'b00_00_00_00, 4'b0000, {10'd8,   10'd8,   10'd8, 10'd8});
    vecs[1] = mk("ch2_stuck0",    4'b0000, 8'b00_01_00_00, 4'b0100, {10'd8,   10'd280, 10'd8, 10'd8});
    vecs[2] = mk("ch1_stuck1",    4'b0000, 8'b00_00_10_00, 4'b0010, {10'd8,   10'd8,   10'd3, 10'd8});
    vecs[3] = mk("mask_1010",     4'b1010, 8'b00_00_00_00, 4'b0000, {10'd0,   10'd8,   10'd0, 10'd8});
    vecs[4] = mk("masked_bad_ch", 4'b0100, 8'b00_01_00_00, 4'b0000, {10'd8,   10'd0,   10'd8, 10'd8});
    vecs[5] = mk("ch0z_ch3o",     4'b0000, 8'b10_00_00_01, 4'b1001, {10'd3,   10'd8,   10'd8, 10'd280});
    vecs[6] = mk("mask_all",      4'b1111, 8'b00_00_00_00, 4'b0000, {10'd0,   10'd0,   10'd0, 10'd0});

    // Reset state
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check("reset.force", 32'(o_bist_force), 32'd0);
    check("reset.flags", {27'd0, o_bist_busy, o_bist_done, o_abist_fail, o_lbist_en, 1'b0}, 32'd0);
    check("reset.fail",  32'(o_ch_fail), 32'd0);

    // Table-driven sessions
    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // All channels masked: done 6 cycles after enable, busy for 5, no force
    i_ch_mask = 4'b1111;
    set_modes(8'h00);
    i_bist_en = 1'b1;
    cnt = 0; busy_cnt = 0; force_seen = 0;
    while (!o_bist_done && cnt < 20) begin
      @(negedge i_clk);
      cnt++;
      if (o_bist_busy) busy_cnt++;
      if (o_bist_force != '0) force_seen++;
    end
    check("mask_all.done_latency", 32'(cnt), 32'd6);
    check("mask_all.busy_cycles", 32'(busy_cnt), 32'd5);
    check("mask_all.no_force", 32'(force_seen), 32'd0);
    idle_cycles(8);

    // Glitch filter on channel 0: 0, 1,1, 0, then 1 until the force ends
    i_ch_mask = 4'b1110;
    set_modes({2'd0, 2'd0, 2'd0, 2'd3});
    script_flag = 1'b0;
    i_bist_en = 1'b1;
    cnt = 0; busy_cnt = 0;
    while (!o_bist_done && busy_cnt < BUDGET) begin
      @(negedge i_clk);
      busy_cnt++;
      if (o_bist_force[0]) begin
        script_flag = (cnt == 1 || cnt == 2 || cnt >= 4);
        cnt++;
      end else begin
        script_flag = 1'b0;
      end
    end
    check("glitch.force_len", 32'(cnt), 32'd7);
    check("glitch.done", 32'(o_bist_done), 32'd1);
    check("glitch.fail", 32'(o_ch_fail), 32'd0);
    idle_cycles(8);

    // Abort in cycle 100 of channel 1 FORCE, then restart from channel 0
    i_ch_mask = 4'b0000;
    set_modes({2'd0, 2'd0, 2'd1, 2'd2});
    i_bist_en = 1'b1;
    cnt = 0; busy_cnt = 0;
    while (cnt < 100 && busy_cnt < BUDGET) begin
      @(negedge i_clk);
      busy_cnt++;
      if (o_bist_force[1]) cnt++;
    end
    check("abort.reached_ch1_cycle100", 32'(cnt), 32'd100);
    check("abort.pre_fail", 32'(o_ch_fail), 32'b0001);
    check("abort.pre_busy", 32'(o_bist_busy), 32'd1);
    i_bist_en = 1'b0;
    @(negedge i_clk);
    check("abort.force", 32'(o_bist_force), 32'd0);
    check("abort.fail",  32'(o_ch_fail), 32'd0);
    check("abort.flags", {28'd0, o_bist_busy, o_bist_done, o_abist_fail, o_lbist_en}, 32'd0);
    repeat (6) @(negedge i_clk);
    set_modes(8'h00);
    i_bist_en = 1'b1;
    cnt = 0;
    while (o_bist_force == '0 && cnt < 20) begin
      @(negedge i_clk);
      cnt++;
    end
    check("abort.restart_ch0", 32'(o_bist_force), 32'b0001);
    idle_cycles(8);

    // Asynchronous reset in the middle of channel 1 RELEASE
    set_modes({2'd0, 2'd0, 2'd2, 2'd2});
    i_bist_en = 1'b1;
    seen = 1'b0; cnt = 0;
    while (!(seen && !o_bist_force[1]) && cnt < BUDGET) begin
      @(negedge i_clk);
      cnt++;
      if (o_bist_force[1]) seen = 1'b1;
    end
    repeat (10) @(negedge i_clk);
    check("rst.pre_fail", 32'(o_ch_fail), 32'b0001);
    check("rst.pre_busy_abist", {30'd0, o_bist_busy, o_abist_fail}, 32'd3);
    #1 i_rst_n = 1'b0;
    #1;
    check("rst.async_fail", 32'(o_ch_fail), 32'd0);
    check("rst.async_flags", {28'd0, o_bist_busy, o_bist_done, o_abist_fail, o_lbist_en}, 32'd0);
    check("rst.async_force", 32'(o_bist_force), 32'd0);
    i_bist_en = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (3) @(negedge i_clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
